// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM copy master: moves a block of 32-bit words inside a single-port RAM,
// one read then one write per word, and keeps a wrapping checksum of the words read.
module onchip_mem_copy_master #(
  parameter int MEM_DEPTH    = 50000,
  parameter int READ_LATENCY = 1      // 1..4 cycles from read command to readdata
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum,
  output logic [15:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [16:0] DEPTH     = 17'(MEM_DEPTH);
  localparam logic [1:0]  WAIT_LAST = 2'(READ_LATENCY - 1);

  logic [2:0]  state;
  logic [15:0] src, dst, cnt, idx;
  logic [1:0]  wcnt;
  logic [31:0] data;
  logic [31:0] sum;
  logic        err;
  logic [16:0] src_end, dst_end;

  // Range check is done one bit wider so a block ending exactly at MEM_DEPTH is legal.
  assign src_end = {1'b0, src_addr} + {1'b0, word_count};
  assign dst_end = {1'b0, dst_addr} + {1'b0, word_count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      idx   <= '0;
      wcnt  <= '0;
      data  <= '0;
      sum   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src <= src_addr;
            dst <= dst_addr;
            cnt <= word_count;
            idx <= '0;
            sum <= '0;
            err <= 1'b0;
            if (word_count == 16'd0) begin
              state <= S_DONE;
            end else if (src_end > DEPTH || dst_end > DEPTH) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WAIT_LAST) begin
            data  <= mem_readdata;
            sum   <= sum + mem_readdata;
            state <= S_WRITE;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (idx == cnt - 16'd1) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 16'd1;
            state <= S_READ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so reset clears them asynchronously.
  assign busy           = (state == S_READ) || (state == S_WAIT) || (state == S_WRITE);
  assign done           = (state == S_DONE);
  assign error          = err;
  assign checksum       = sum;
  assign mem_chipselect = (state == S_READ) || (state == S_WRITE);
  assign mem_write      = (state == S_WRITE);
  assign mem_address    = (state == S_WRITE) ? dst + idx :
                          (state == S_READ)  ? src + idx : 16'd0;
  assign mem_writedata  = (state == S_WRITE) ? data : 32'd0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Scoreboard bench: two copy masters (read latency 1 and 3) each on its own RAM model;
// expected writes and done records are queued at launch and popped as the DUT produces them.
module tb_onchip_mem_copy_master;

  typedef struct {logic [15:0] a; logic [31:0] d;} wr_t;
  typedef struct {int lat; logic [31:0] sum; logic err;} dn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: READ_LATENCY=1
  logic        start0;
  logic [15:0] src0, dst0, cnt0, addr0;
  logic        busy0, done0, error0, cs0, we0, ce0;
  logic [31:0] sum0, wd0, rd0;
  logic [3:0]  be0;
  logic [31:0] mem0 [0:65535];

  // instance 1: READ_LATENCY=3
  logic        start1;
  logic [15:0] src1, dst1, cnt1, addr1;
  logic        busy1, done1, error1, cs1, we1, ce1;
  logic [31:0] sum1, wd1, rd1, p1a, p1b;
  logic [3:0]  be1;
  logic [31:0] mem1 [0:255];

  onchip_mem_copy_master #(.MEM_DEPTH(50000), .READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .start(start0), .src_addr(src0), .dst_addr(dst0),
    .word_count(cnt0), .busy(busy0), .done(done0), .error(error0), .checksum(sum0),
    .mem_address(addr0), .mem_chipselect(cs0), .mem_write(we0), .mem_writedata(wd0),
    .mem_byteenable(be0), .mem_clken(ce0), .mem_readdata(rd0));

  onchip_mem_copy_master #(.MEM_DEPTH(256), .READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .start(start1), .src_addr(src1), .dst_addr(dst1),
    .word_count(cnt1), .busy(busy1), .done(done1), .error(error1), .checksum(sum1),
    .mem_address(addr1), .mem_chipselect(cs1), .mem_write(we1), .mem_writedata(wd1),
    .mem_byteenable(be1), .mem_clken(ce1), .mem_readdata(rd1));

  // RAM models
  always @(posedge clk) begin
    if (cs0 && we0) mem0[addr0] <= wd0;
    rd0 <= mem0[addr0];
    if (cs1 && we1) mem1[addr1[7:0]] <= wd1;
    p1a <= mem1[addr1[7:0]];
    p1b <= p1a;
    rd1 <= p1b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  wr_t wq0[$], wq1[$];
  dn_t dq0[$], dq1[$];
  int  s0, s1, nd0 = 0, nd1 = 0, nrd0 = 0, nwr0 = 0, nrd1 = 0, nwr1 = 0, nbusy0 = 0;

  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    if (cs0) begin
      if (we0) begin
        nwr0++;
        if (wq0.size() == 0) check("wr0_extra", 1, 0);
        else begin
          w = wq0.pop_front();
          check("wr0_addr", addr0, w.a);
          check("wr0_data", wd0, w.d);
        end
      end else nrd0++;
    end
    if (busy0) nbusy0++;
    if (done0) begin
      nd0++;
      if (dq0.size() == 0) check("done0_extra", 1, 0);
      else begin
        d = dq0.pop_front();
        check("done0_lat", cyc - s0, d.lat);
        check("done0_sum", sum0, d.sum);
        check("done0_err", error0, d.err);
      end
    end
    if (cs1) begin
      if (we1) begin
        nwr1++;
        if (wq1.size() == 0) check("wr1_extra", 1, 0);
        else begin
          w = wq1.pop_front();
          check("wr1_addr", addr1, w.a);
          check("wr1_data", wd1, w.d);
        end
      end else nrd1++;
    end
    if (done1) begin
      nd1++;
      if (dq1.size() == 0) check("done1_extra", 1, 0);
      else begin
        d = dq1.pop_front();
        check("done1_lat", cyc - s1, d.lat);
        check("done1_sum", sum1, d.sum);
        check("done1_err", error1, d.err);
      end
    end
  end

  // call at a negedge; the following posedge is the start edge
  task automatic go0(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    src0 = s; dst0 = d; cnt0 = n; start0 = 1'b1; s0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int target);
    for (int k = 0; k < 300 && nd0 < target; k++) @(negedge clk);
    check("done0_timeout", nd0, target);
    @(negedge clk);
  endtask

  task automatic push_wr0(input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq0.push_back(w);
  endtask

  task automatic push_dn0(input int lat, input logic [31:0] sum, input logic err);
    dn_t d;
    d.lat = lat; d.sum = sum; d.err = err;
    dq0.push_back(d);
  endtask

  initial begin : main
    int acc;
    wr_t w;
    dn_t d;
    for (int i = 0; i < 65536; i++) mem0[i] = 32'd0;
    for (int i = 0; i < 256; i++) mem1[i] = 32'd0;
    start0 = 0; src0 = 0; dst0 = 0; cnt0 = 0;
    start1 = 0; src1 = 0; dst1 = 0; cnt1 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_error", error0, 0);
    check("rst_sum", sum0, 0);
    check("rst_cs", cs0, 0);
    check("rst_we", we0, 0);
    check("rst_addr", addr0, 0);
    check("rst_wd", wd0, 0);
    check("rst_be", be0, 32'hF);
    check("rst_ce", ce0, 1);

    // basic 4-word copy
    for (int i = 0; i < 4; i++) begin
      mem0[100 + i] = i + 1;
      push_wr0(16'(200 + i), 32'(i + 1));
    end
    push_dn0(13, 32'd10, 1'b0);
    nrd0 = 0; nwr0 = 0; nbusy0 = 0;
    go0(100, 200, 4);
    wait_done0(1);
    for (int i = 0; i < 4; i++) check("t1_mem", mem0[200 + i], 32'(i + 1));
    check("t1_reads", nrd0, 4);
    check("t1_writes", nwr0, 4);
    check("t1_busy", nbusy0, 12);

    // zero count, then out-of-range, then exactly-at-end
    acc = nrd0 + nwr0;
    push_dn0(1, 32'd0, 1'b0);
    go0(0, 0, 0);
    wait_done0(2);
    push_dn0(1, 32'd0, 1'b1);
    go0(49999, 300, 2);
    wait_done0(3);
    check("t2_no_access", nrd0 + nwr0, acc);
    repeat (3) @(negedge clk);
    check("t2_err_held", error0, 1);
    mem0[49998] = 32'd5; mem0[49999] = 32'd6;
    push_wr0(300, 5); push_wr0(301, 6);
    push_dn0(7, 32'd11, 1'b0);
    go0(49998, 300, 2);
    wait_done0(4);
    check("t2_err_cleared", error0, 0);

    // checksum wrap
    mem0[500] = 32'hFFFFFFFF; mem0[501] = 32'h2;
    push_wr0(600, 32'hFFFFFFFF); push_wr0(601, 32'h2);
    push_dn0(7, 32'h1, 1'b0);
    go0(500, 600, 2);
    wait_done0(5);
    repeat (2) @(negedge clk);
    check("t3_sum_held", sum0, 32'h1);

    // forward-overlapping copy propagates the first word
    mem0[10] = 32'hA; mem0[11] = 32'hB; mem0[12] = 32'hC; mem0[13] = 32'h0;
    for (int i = 0; i < 3; i++) push_wr0(16'(11 + i), 32'hA);
    push_dn0(10, 32'h1E, 1'b0);
    go0(10, 11, 3);
    wait_done0(6);
    for (int i = 0; i < 4; i++) check("t4_mem", mem0[10 + i], 32'hA);

    // RL=3: 2-word copy with start pulsed while busy and in DONE
    mem1[20] = 32'd7; mem1[21] = 32'd8;
    w.a = 40; w.d = 7; wq1.push_back(w);
    w.a = 41; w.d = 8; wq1.push_back(w);
    d.lat = 11; d.sum = 15; d.err = 1'b0; dq1.push_back(d);
    src1 = 20; dst1 = 40; cnt1 = 2; start1 = 1'b1; s1 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 50 && cyc - s1 < 11; k++) @(negedge clk);
    check("t5_done_cycle", done1, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_single_done", nd1, 1);
    check("t5_reads", nrd1, 2);
    check("t5_writes", nwr1, 2);
    check("t5_mem0", mem1[40], 7);
    check("t5_mem1", mem1[41], 8);

    // reset during the third word's WAIT
    for (int i = 0; i < 4; i++) begin
      mem0[700 + i] = 32'(11 + i);
      mem0[800 + i] = 32'd0;
    end
    push_wr0(800, 11); push_wr0(801, 12);
    go0(700, 800, 4);
    for (int k = 0; k < 50 && cyc - s0 < 8; k++) @(negedge clk);
    check("t6_pre_busy", busy0, 1);
    check("t6_pre_sum", sum0, 32'd23);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy0, 0);
    check("t6_done", done0, 0);
    check("t6_cs", cs0, 0);
    check("t6_we", we0, 0);
    check("t6_addr", addr0, 0);
    check("t6_sum", sum0, 0);
    acc = nrd0 + nwr0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_access", nrd0 + nwr0, acc);
    check("t6_w0", mem0[800], 11);
    check("t6_w1", mem0[801], 12);
    check("t6_w2", mem0[802], 0);
    check("t6_wq_empty", wq0.size(), 0);
    check("t6_dq_empty", dq0.size(), 0);
    check("t6_nd0", nd0, 6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/onchip_mem_copy_master.md
# onchip_mem_copy_master

Avalon-MM master that copies a block of 32-bit words inside a single-port on-chip RAM, driving the same slave port signals (address, byteenable, chipselect, write, writedata, clken) that the RAM's s1 slave accepts and consuming its fixed-latency readdata. It sits beside each processor's on-chip memory, on the slave side of the arbiter, and offloads buffer moves between processing stages. It also returns a running 32-bit checksum of the words moved.

## Interface

- MEM_DEPTH, 50000: RAM depth in words; it bounds legal addresses.
- READ_LATENCY, 1: cycles from the read command cycle to valid readdata (1 matches an unregistered-output RAM). Legal range is 1..4.
- clk  in  1  single clock; everything is sampled on its rising edge.
- reset_n  in  1  reset, asynchronous assert and active-low; deassertion is synchronous to clk.
- start  in  1  pulse that requests a copy; it is sampled only in IDLE.
- src_addr  in  16  first source word address.
- dst_addr  in  16  first destination word address.
- word_count  in  16  number of words to copy.
- busy  out  1  high in READ, WAIT and WRITE.
- done  out  1  one-cycle pulse at the end of every accepted request.
- error  out  1  set when a request is rejected; it is held until the next accepted start.
- checksum  out  32  wrapping sum of the words read; it is held until the next accepted start.
- mem_address  out  16  word address to the RAM.
- mem_chipselect  out  1  RAM access strobe.
- mem_write  out  1  RAM write (1) or read (0).
- mem_writedata  out  32  write data.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  32  RAM read data.

## Operation

- States: IDLE, READ, WAIT, WRITE, DONE.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, error=0, checksum=0.
  - mem_address=0, mem_chipselect=0, mem_write=0, mem_writedata=0.
- IDLE with start=1 latches src, dst and count, and clears checksum and error. It then branches:
  - word_count=0: go to DONE. No RAM access; checksum stays 0.
  - src_addr+word_count > MEM_DEPTH, or dst_addr+word_count > MEM_DEPTH (computed at 17 bits): error=1, go to DONE, no RAM access.
  - Otherwise: go to READ with index i=0.
- READ: mem_chipselect=1, mem_write=0, mem_address=src+i. Next state is WAIT.
- WAIT: lasts READ_LATENCY cycles with chipselect=0.
  - On its last cycle, latch mem_readdata into the data register and add it to checksum (mod 2^32).
  - Next state is WRITE.
- WRITE: mem_chipselect=1, mem_write=1, mem_address=dst+i, mem_writedata=latched word.
  - If i=count-1, go to DONE.
  - Otherwise increment i and go to READ.
- DONE: done=1 for one cycle, then IDLE.
- Copy order is strictly ascending and each word is read, then written, before the next read. Overlap is therefore defined: when dst>src the copy propagates forward; this is intended and is not an error.
- start outside IDLE (including in DONE) is ignored and is not queued.
- mem_chipselect is 0 in IDLE, WAIT and DONE. mem_address and mem_writedata are don't-care when chipselect=0.
- Reset mid-operation aborts immediately with no further RAM access. Words already written stay written.

## Timing

- The start edge is E0; busy rises after E0.
- Per word the sequence takes 2+READ_LATENCY cycles: READ, WAIT×READ_LATENCY, WRITE.
- For N>0 words, done is high in cycle E0 + N·(2+READ_LATENCY) + 1. For N=0 or error, done is high in the cycle immediately after E0.
- checksum and error are valid from the done cycle onward.
- A new start is accepted in the first IDLE cycle after DONE. The minimum request-to-request spacing is N·(2+RL)+2 cycles.

## Test plan

- RAM preload [100..103]=1,2,3,4; src=100, dst=200, count=4, RL=1.
  - Expect [200..203]=1,2,3,4 and checksum=10.
  - Expect done in cycle 13 after start and busy high for 12 cycles.
  - Expect exactly 4 reads and 4 writes.
- count=0 → done in the next cycle, error=0, checksum=0, no chipselect. Then src=49999, count=2 → error=1, done next cycle, no chipselect.
- Checksum wrap: words 32'hFFFFFFFF and 32'h00000002 → checksum=32'h00000001.
- Overlap: [10..12]=A,B,C; src=10, dst=11, count=3 → [10..13]=A,A,A,A.
- Start pulsed while busy, and again in DONE → no effect, single done pulse. With RL=3, a 2-word copy gives done in cycle 11.
- reset_n low during the third word's WAIT → all outputs take reset values asynchronously. Words 0 and 1 are copied, word 2 is untouched, and no access occurs after reset.
